// File: rtl/max_calc_pkg.sv
// Shared types and default sizing for the sequential max calculator.
package max_calc_pkg;

  localparam int DEF_NUM = 4;
  localparam int DEF_W   = 4;
  localparam int DEF_IW  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/max_step_cmp.sv
// One compare step of the running max: pick the candidate when it is the first operand or strictly larger.
module max_step_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] cur_max,
  input  logic [W-1:0] cand,
  input  logic         first,
  output logic         take,
  output logic [W-1:0] next_max
);

  // Strict compare so ties keep the earlier operand.
  assign take     = first | (cand > cur_max);
  assign next_max = take ? cand : cur_max;

endmodule

// File: rtl/max_calculator_seq.sv
// Running max over NUM operands accepted on a valid/ready stream; done one cycle after the last accept.
// in_ready is a pure state decode (high only in LOAD); in_valid low stalls the run indefinitely.
module max_calculator_seq
  import max_calc_pkg::*;
#(
  parameter int NUM = DEF_NUM,
  parameter int W   = DEF_W,
  parameter int IW  = DEF_IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  max_out,
  output logic [IW-1:0]   max_idx
);

  state_t          state, state_nxt;
  logic [IW-1:0]   count;
  logic [W-1:0]    max_q;
  logic            accept;
  logic            last;
  logic            take;
  logic [W-1:0]    next_max;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign max_out  = {{W{1'b0}}, max_q};

  assign accept = in_valid & in_ready;
  assign last   = (count == IW'(NUM - 1));

  max_step_cmp #(.W(W)) u_cmp (
    .cur_max  (max_q),
    .cand     (in_data),
    .first    (count == '0),
    .take     (take),
    .next_max (next_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      max_q   <= '0;
      max_idx <= '0;
    end else if (state == IDLE && start) begin
      count   <= '0;
      max_q   <= '0;
      max_idx <= '0;
    end else if (accept) begin
      if (take) begin
        max_q   <= next_max;
        max_idx <= count;
      end
      count <= count + 1'b1;
    end
  end

endmodule

// File: doc/max_calculator_seq.md
Name: max_calculator_seq

Overview:
Sequential counterpart to the combinational min path: accepts a stream of NUM unsigned W-bit operands over a valid/ready handshake and reports their maximum.
- Result is zero-extended to 2W bits, matching the min result width.
- Also reports the index of the winning operand.
- Sits between an operand producer (switch/register front end) and the result display/compare logic.

Parameters:
- NUM, 4, number of operands per run (2..15).
- W, 4, operand width in bits.
- IW, 4, index/counter width; must satisfy 2^IW > NUM.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new run; sampled only in IDLE
- in_valid  input  1  operand on in_data is valid
- in_data  input  W  unsigned operand
- in_ready  output  1  block accepts an operand this cycle
- busy  output  1  high in LOAD and DONE
- done  output  1  one-cycle pulse, result valid
- max_out  output  2W  zero-extended maximum; upper W bits always 0
- max_idx  output  IW  0-based arrival index of the maximum

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, max_out=0, max_idx=0, done=0, in_ready=0, busy=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD next cycle; count, max_out and max_idx clear to 0 on that edge.
  - in_valid is ignored.
- LOAD:
  - in_ready=1, busy=1.
  - An accept is in_valid & in_ready at a rising edge.
  - On each accept: if count==0 or in_data > max_out[W-1:0] (strictly greater), load max_out={0,in_data} and max_idx=count. Then count++.
  - Ties keep the earlier index.
  - start is ignored.
  - in_valid=0 stalls indefinitely with no state change.
- LOAD -> DONE: on the accept where count==NUM-1, the last operand is included in the compare that same edge.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, in_ready=0.
  - Next state is IDLE; in_valid and start are ignored.
- After DONE: max_out and max_idx hold their value in IDLE until the next accepted start clears them.
- Latency:
  - done asserts in the cycle after the NUM-th accept.
  - Minimum run is NUM+1 cycles after the start edge.
- Back-to-back runs: start sampled in the IDLE cycle right after DONE is legal.
- Reset mid-run: all state and outputs return to reset values immediately; any partial result is discarded.
- All-equal operands: max_idx=0.
- All-zero operands: max_out=0, max_idx=0.
- Compare rule:
  - Unsigned W-bit compare; no overflow is possible.
  - max_out[2W-1:W] is tied to 0.
- done and in_ready are registered-state decodes only; no combinational path from in_valid to in_ready.

Decomposition:
- Shared package max_calc_pkg holds:
  - state enum typedef (IDLE, LOAD, DONE);
  - default constants NUM, W, IW.
- One sub-module, max_step_cmp (combinational):
  - inputs: current max, candidate, first flag;
  - outputs: take-candidate select and next max value.
  - Built on the existing 4-bit comparator and 2:1 4-bit mux cells when W=4.
- FSM, counter and result registers stay in the top.

Test Plan:
- Reset then start; stream 3,9,2,7 with in_valid held high -> in_ready high for 4 cycles, done pulses 1 cycle later, max_out=8'h09, max_idx=1.
- Stream 5,5,1,5 -> max_out=8'h05, max_idx=0 (tie keeps first).
- Stream 0,0,0,15 with in_valid low for 3 cycles between operands -> no extra accepts during gaps; max_out=8'h0F, max_idx=3, done exactly once.
- start pulsed during LOAD and in_valid=1 during IDLE/DONE -> no effect; count and result unchanged; in_ready=0 outside LOAD.
- Assert rst after 2 accepts (8,4) -> all outputs 0 immediately; new run 1,2,3,4 -> max_out=8'h04, max_idx=3.
- Back-to-back: start in the cycle after done -> second run 6,0,0,0 gives max_out=8'h06, max_idx=0; first result held in IDLE until that start.
